// File: rtl/ioctl_rom_router_pkg.sv
// ioctl_pkg: shared constants for the HPS ioctl ROM router.
// Holds the ioctl index assignments, the default region map, the router
// FSM state type with its state constants, and a byte-lane helper.
package ioctl_pkg;

  localparam int DEF_NUM_REGIONS = 2;
  localparam int DEF_ADDR_W      = 25;
  localparam int DEF_DIP_BYTES   = 8;
  localparam int DEF_RST_CNT_W   = 16;
  localparam int DEF_TIMEOUT     = 1024;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  // Region 0 is the low entry: {region1, region0}.
  localparam logic [DEF_NUM_REGIONS-1:0][DEF_ADDR_W-1:0] DEF_REGION_BASE =
    {25'h0030000, 25'h0000000};
  localparam logic [DEF_NUM_REGIONS-1:0][DEF_ADDR_W-1:0] DEF_REGION_SIZE =
    {25'h0070000, 25'h00A0000};

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE     = 1'b0;
  localparam fsm_state_t ST_WAIT_ACK = 1'b1;

  // 16-bit memory byte strobes: odd address selects the upper lane.
  function automatic logic [1:0] byteLaneSel(input logic addrLsb);
    return {addrLsb, ~addrLsb};
  endfunction

endpackage

// File: rtl/ioctl_rom_router_if.sv
// Bus interfaces for the ioctl ROM router.
// ioctl_bus_if: HPS download bus (master = HPS, slave = router).
//   ioctl_download/wr/addr/dout/index toward the router, ioctl_wait back.
// rom_port_if: toggle-handshake write port toward the ROM memories
//   (master = router, slave = memories). region_req/offset/dl_data/dl_ds
//   toward memories, region_ack back.

interface ioctl_bus_if #(
  parameter int ADDR_W = 25
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait
  );
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait
  );
endinterface

interface rom_port_if #(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W      = 25
);
  logic [NUM_REGIONS-1:0]        region_req;
  logic [NUM_REGIONS-1:0]        region_ack;
  logic [NUM_REGIONS*ADDR_W-1:0] region_offset;
  logic [7:0]                    dl_data;
  logic [1:0]                    dl_ds;

  modport master (
    output region_req, region_offset, dl_data, dl_ds,
    input  region_ack
  );
  modport slave (
    input  region_req, region_offset, dl_data, dl_ds,
    output region_ack
  );
endinterface

// File: rtl/ioctl_rom_router_core_reset_gen.sv
// core_reset_gen: holds the core in reset while i_hold is high, then
// counts down from all-ones and releases o_coreReset once it reaches 0.
// Ports: clk_sys, rst_n (async active-low), i_hold (reload request),
//        o_coreReset (registered, high while the counter is non-zero).
module core_reset_gen #(
  parameter int RST_CNT_W = 16
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic i_hold,
  output logic o_coreReset
);

  logic [RST_CNT_W-1:0] r_cnt;
  logic                 r_coreReset;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '1;
      r_coreReset <= 1'b1;
    end else begin
      if (i_hold)
        r_cnt <= '1;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      r_coreReset <= (r_cnt != '0);
    end
  end

  assign o_coreReset = r_coreReset;

endmodule

// File: rtl/ioctl_rom_router.sv
// ioctl_rom_router: routes HPS ioctl ROM download bytes to one or more
// memory regions via toggle req/ack handshakes, captures the core-mod byte
// and DIP bytes, and sequences the core reset after the ROM has loaded.
// Ports: clk_sys, rst_n (async active-low); ioctl (ioctl_bus_if.slave);
//        rom (rom_port_if.master); soft_reset in; core_mod, dip,
//        rom_loaded, core_reset, err_overrun, err_timeout out.
module ioctl_rom_router
  import ioctl_pkg::*;
#(
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_SIZE = DEF_REGION_SIZE,
  parameter logic [7:0] ROM_INDEX = IDX_ROM,
  parameter logic [7:0] MOD_INDEX = IDX_MOD,
  parameter logic [7:0] DIP_INDEX = IDX_DIP,
  parameter int DIP_BYTES   = DEF_DIP_BYTES,
  parameter int RST_CNT_W   = DEF_RST_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  ioctl_bus_if.slave             ioctl,
  rom_port_if.master             rom,
  input  logic                   soft_reset,
  output logic [7:0]             core_mod,
  output logic [DIP_BYTES*8-1:0] dip,
  output logic                   rom_loaded,
  output logic                   core_reset,
  output logic                   err_overrun,
  output logic                   err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  fsm_state_t                         r_state;
  logic                               r_wrPrev;
  logic                               r_dlPrev;
  logic [NUM_REGIONS-1:0]             r_req;
  logic [NUM_REGIONS-1:0][ADDR_W-1:0] r_offset;
  logic [7:0]                         r_dlData;
  logic [1:0]                         r_dlDs;
  logic [TO_W-1:0]                    r_waitCnt;
  logic                               r_errOverrun;
  logic                               r_errTimeout;
  logic                               r_romLoaded;
  logic [7:0]                         r_coreMod;
  logic [DIP_BYTES-1:0][7:0]          r_dip;

  logic                   w_wrEvent;
  logic                   w_isRom;
  logic                   w_romWrite;
  logic                   w_dlRise;
  logic                   w_dlFall;
  logic                   w_holdReset;
  logic [NUM_REGIONS-1:0] w_hit;
  logic [NUM_REGIONS-1:0] w_pending;

  assign w_wrEvent   = ioctl.ioctl_wr & ~r_wrPrev;
  assign w_isRom     = (ioctl.ioctl_index == ROM_INDEX);
  assign w_romWrite  = w_wrEvent & ioctl.ioctl_download & w_isRom;
  assign w_dlRise    = ioctl.ioctl_download & ~r_dlPrev & w_isRom;
  assign w_dlFall    = ~ioctl.ioctl_download & r_dlPrev & w_isRom;
  assign w_pending   = r_req ^ rom.region_ack;
  assign w_holdReset = soft_reset | ~r_romLoaded | (ioctl.ioctl_download & w_isRom);

  // One extra bit keeps base+size from wrapping at the top of the space.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_hit[i] = ({1'b0, ioctl.ioctl_addr} >= {1'b0, REGION_BASE[i]}) &&
                 ({1'b0, ioctl.ioctl_addr} <
                  ({1'b0, REGION_BASE[i]} + {1'b0, REGION_SIZE[i]}));
    end
  end

  // wr copy resets high so a strobe held across reset release is not an event.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPrev <= 1'b1;
      r_dlPrev <= 1'b0;
    end else begin
      r_wrPrev <= ioctl.ioctl_wr;
      r_dlPrev <= ioctl.ioctl_download;
    end
  end

  // Error clear on a new ROM download comes first so a same-cycle set wins.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_offset     <= '0;
      r_dlData     <= '0;
      r_dlDs       <= '0;
      r_waitCnt    <= '0;
      r_errOverrun <= 1'b0;
      r_errTimeout <= 1'b0;
    end else begin
      if (w_dlRise) begin
        r_errOverrun <= 1'b0;
        r_errTimeout <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_romWrite && (w_hit != '0)) begin
            r_dlData  <= ioctl.ioctl_dout;
            r_dlDs    <= byteLaneSel(ioctl.ioctl_addr[0]);
            for (int i = 0; i < NUM_REGIONS; i++)
              r_offset[i] <= ioctl.ioctl_addr - REGION_BASE[i];
            r_req     <= r_req ^ w_hit;
            r_waitCnt <= '0;
            r_state   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (w_romWrite)
            r_errOverrun <= 1'b1;
          if (w_pending == '0) begin
            r_state <= ST_IDLE;
          end else if (r_waitCnt == TO_W'(TIMEOUT - 1)) begin
            r_errTimeout <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_coreMod   <= '0;
      r_dip       <= '0;
      r_romLoaded <= 1'b0;
    end else begin
      if (w_dlFall)
        r_romLoaded <= 1'b1;
      if (w_wrEvent && (ioctl.ioctl_index == MOD_INDEX))
        r_coreMod <= ioctl.ioctl_dout;
      if (w_wrEvent && (ioctl.ioctl_index == DIP_INDEX)) begin
        for (int b = 0; b < DIP_BYTES; b++)
          if (ioctl.ioctl_addr == ADDR_W'(b))
            r_dip[b] <= ioctl.ioctl_dout;
      end
    end
  end

  core_reset_gen #(
    .RST_CNT_W (RST_CNT_W)
  ) u_coreResetGen (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .i_hold      (w_holdReset),
    .o_coreReset (core_reset)
  );

  assign ioctl.ioctl_wait  = (r_state == ST_WAIT_ACK);
  assign rom.region_req    = r_req;
  assign rom.region_offset = r_offset;
  assign rom.dl_data       = r_dlData;
  assign rom.dl_ds         = r_dlDs;
  assign core_mod          = r_coreMod;
  assign dip               = r_dip;
  assign rom_loaded        = r_romLoaded;
  assign err_overrun       = r_errOverrun;
  assign err_timeout       = r_errTimeout;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Testbench for ioctl_rom_router: directed ioctl writes with hand-computed
// expectations; a scoreboard queue holds the expected request toggle for
// each routed ROM write and a monitor checks it when region_req changes.
module tb_ioctl_rom_router;
  import ioctl_pkg::*;

  localparam int AW = 25;

  typedef struct {
    logic [1:0]    mask;
    logic [AW-1:0] off0;
    logic [AW-1:0] off1;
    logic [7:0]    data;
    logic [1:0]    ds;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_reset = 1'b0;
  logic [7:0]  core_mod;
  logic [63:0] dip;
  logic        rom_loaded;
  logic        core_reset;
  logic        err_overrun;
  logic        err_timeout;
  logic        ackEnable = 1'b1;

  int   errors = 0;
  int   checks = 0;
  exp_t expQ[$];

  ioctl_bus_if #(.ADDR_W(AW)) bus ();
  rom_port_if  #(.NUM_REGIONS(2), .ADDR_W(AW)) rom ();

  ioctl_rom_router #(.NUM_REGIONS(2), .ADDR_W(AW)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .ioctl       (bus),
    .rom         (rom),
    .soft_reset  (soft_reset),
    .core_mod    (core_mod),
    .dip         (dip),
    .rom_loaded  (rom_loaded),
    .core_reset  (core_reset),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one ioctl write strobe; returns at the negedge after the capture edge.
  task automatic applyStimulus(input logic [7:0] idx, input logic [AW-1:0] addr,
                               input logic [7:0] data);
    @(negedge clk_sys);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = addr;
    bus.ioctl_dout  = data;
    bus.ioctl_wr    = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr    = 1'b0;
  endtask

  task automatic measureWait(input string name, input int expCycles);
    int n = 0;
    while (bus.ioctl_wait === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk_sys);
    end
    checkOutput(name, 64'(n), 64'(expCycles));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_region_req"}, 64'(rom.region_req), 64'h0);
    checkOutput({tag, "_region_offset"}, 64'(rom.region_offset), 64'h0);
    checkOutput({tag, "_dl_data"}, 64'(rom.dl_data), 64'h0);
    checkOutput({tag, "_dl_ds"}, 64'(rom.dl_ds), 64'h0);
    checkOutput({tag, "_ioctl_wait"}, 64'(bus.ioctl_wait), 64'h0);
    checkOutput({tag, "_core_mod"}, 64'(core_mod), 64'h0);
    checkOutput({tag, "_dip"}, dip, 64'h0);
    checkOutput({tag, "_rom_loaded"}, 64'(rom_loaded), 64'h0);
    checkOutput({tag, "_core_reset"}, 64'(core_reset), 64'h1);
    checkOutput({tag, "_err_overrun"}, 64'(err_overrun), 64'h0);
    checkOutput({tag, "_err_timeout"}, 64'(err_timeout), 64'h0);
  endtask

  // Memory model: acknowledges outstanding requests three cycles after seeing them.
  initial begin
    rom.region_ack = '0;
    forever begin
      @(negedge clk_sys);
      if (!rst_n) begin
        rom.region_ack = '0;
      end else if (ackEnable && (rom.region_req !== rom.region_ack)) begin
        repeat (3) @(negedge clk_sys);
        if (rst_n && ackEnable)
          rom.region_ack = rom.region_req;
      end
    end
  end

  // Scoreboard monitor: every change of region_req must match the queue head.
  initial begin
    logic [1:0] prevReq;
    exp_t       e;
    prevReq = '0;
    forever begin
      @(negedge clk_sys);
      if (!rst_n) begin
        prevReq = '0;
      end else if (rom.region_req !== prevReq) begin
        if (expQ.size() == 0) begin
          checkOutput("sb_unexpected_toggle", 64'(rom.region_req ^ prevReq), 64'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_toggle_mask", 64'(rom.region_req ^ prevReq), 64'(e.mask));
          checkOutput("sb_offset0", 64'(rom.region_offset[AW-1:0]), 64'(e.off0));
          checkOutput("sb_offset1", 64'(rom.region_offset[2*AW-1:AW]), 64'(e.off1));
          checkOutput("sb_dl_data", 64'(rom.dl_data), 64'(e.data));
          checkOutput("sb_dl_ds", 64'(rom.dl_ds), 64'(e.ds));
        end
        prevReq = rom.region_req;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = IDX_ROM;

    repeat (3) @(negedge clk_sys);
    checkResetValues("in_reset");
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    checkResetValues("after_release");

    // DIP byte 2 written, address 9 out of range ignored; MOD last byte wins.
    applyStimulus(IDX_DIP, 25'd2, 8'h5A);
    applyStimulus(IDX_DIP, 25'd9, 8'hFF);
    applyStimulus(IDX_MOD, 25'd0, 8'h33);
    applyStimulus(IDX_MOD, 25'd0, 8'h0B);
    checkOutput("dip_bytes", dip, 64'h0000_0000_005A_0000);
    checkOutput("core_mod", 64'(core_mod), 64'h0B);

    @(negedge clk_sys);
    bus.ioctl_index    = IDX_ROM;
    bus.ioctl_download = 1'b1;

    // Region 0 only; region 1 offset wraps modulo 2^25.
    expQ.push_back('{2'b01, 25'h0000010, 25'h1FD0010, 8'h5A, 2'b01});
    applyStimulus(IDX_ROM, 25'h0000010, 8'h5A);
    measureWait("wait_len_0x00010", 4);

    // Overlap area: both regions, odd address selects upper lane.
    expQ.push_back('{2'b11, 25'h0030001, 25'h0000001, 8'hC3, 2'b10});
    applyStimulus(IDX_ROM, 25'h0030001, 8'hC3);
    measureWait("wait_len_0x30001", 4);

    // First address past both regions: ignored entirely.
    applyStimulus(IDX_ROM, 25'h00A0000, 8'h77);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ioctl_wait === 1'b1) n++;
      @(negedge clk_sys);
    end
    checkOutput("wait_no_hit", 64'(n), 64'h0);
    checkOutput("dl_data_kept_no_hit", 64'(rom.dl_data), 64'hC3);
    checkOutput("err_timeout_clear", 64'(err_timeout), 64'h0);

    // Ack withheld: timeout after 1024 wait cycles, second write overruns.
    ackEnable = 1'b0;
    expQ.push_back('{2'b01, 25'h0000100, 25'h1FD0100, 8'h11, 2'b01});
    applyStimulus(IDX_ROM, 25'h0000100, 8'h11);
    bus.ioctl_addr = 25'h0000200;
    bus.ioctl_dout = 8'h22;
    n = 0;
    while (bus.ioctl_wait === 1'b1 && n < 2000) begin
      bus.ioctl_wr = (n == 10);
      n++;
      @(negedge clk_sys);
    end
    bus.ioctl_wr = 1'b0;
    checkOutput("wait_len_timeout", 64'(n), 64'd1024);
    checkOutput("err_timeout_set", 64'(err_timeout), 64'h1);
    checkOutput("err_overrun_set", 64'(err_overrun), 64'h1);
    ackEnable = 1'b1;
    repeat (6) @(negedge clk_sys);

    // End of download sets rom_loaded; errors stay until the next ROM download.
    checkOutput("rom_loaded_before_end", 64'(rom_loaded), 64'h0);
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    checkOutput("rom_loaded_set", 64'(rom_loaded), 64'h1);
    checkOutput("err_timeout_sticky", 64'(err_timeout), 64'h1);
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    checkOutput("err_timeout_cleared", 64'(err_timeout), 64'h0);
    checkOutput("err_overrun_cleared", 64'(err_overrun), 64'h0);
    checkOutput("core_reset_held_in_dl", 64'(core_reset), 64'h1);

    // Counter decrements 65535 -> 0 over 65535 edges; core_reset drops the edge after.
    bus.ioctl_download = 1'b0;
    n = 0;
    @(negedge clk_sys);
    while (core_reset === 1'b1 && n < 70000) begin
      n++;
      @(negedge clk_sys);
    end
    checkOutput("core_reset_countdown", 64'(n), 64'd65535);
    checkOutput("core_reset_low", 64'(core_reset), 64'h0);

    soft_reset = 1'b1;
    @(negedge clk_sys);
    soft_reset = 1'b0;
    @(negedge clk_sys);
    checkOutput("core_reset_soft", 64'(core_reset), 64'h1);

    // Reset in the middle of a handshake abandons it.
    ackEnable = 1'b0;
    bus.ioctl_download = 1'b1;
    expQ.push_back('{2'b01, 25'h0000021, 25'h1FD0021, 8'h99, 2'b10});
    applyStimulus(IDX_ROM, 25'h0000021, 8'h99);
    repeat (3) @(negedge clk_sys);
    checkOutput("wait_mid_transfer", 64'(bus.ioctl_wait), 64'h1);
    #2 rst_n = 1'b0;
    bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    checkResetValues("midwait_reset");
    ackEnable = 1'b1;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    checkOutput("req_after_release", 64'(rom.region_req), 64'h0);
    checkOutput("wait_after_release", 64'(bus.ioctl_wait), 64'h0);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ioctl_rom_router.md
IOCTL_ROM_ROUTER -- requirements
Module: ioctl_rom_router

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 2, number of ROM target regions (1..8).
REQ-002 SHALL have parameter ADDR_W, default 25, ioctl address width.
REQ-003 SHALL have parameter REGION_BASE, default {0x00000, 0x30000}, NUM_REGIONS x ADDR_W region start addresses.
REQ-004 SHALL have parameter REGION_SIZE, default {0xA0000, 0x70000}, NUM_REGIONS x ADDR_W region byte lengths.
REQ-005 SHALL have parameters ROM_INDEX 0, MOD_INDEX 1, DIP_INDEX 254, DIP_BYTES 8, RST_CNT_W 16, TIMEOUT 1024.
REQ-006 SHALL have ports clk_sys in 1, the single clock, and rst_n in 1, reset; reset is asynchronous and active-low.
REQ-007 SHALL have ports ioctl_download in 1, ioctl_wr in 1, ioctl_addr in ADDR_W, ioctl_dout in 8, ioctl_index in 8 (HPS download bus).
REQ-008 SHALL have ports soft_reset in 1 (menu or button reset) and region_ack in NUM_REGIONS (toggle acks from memory ports).
REQ-009 SHALL have ports region_req out NUM_REGIONS (toggle requests), region_offset out NUM_REGIONS*ADDR_W (addr minus base, per region) and dl_data out 8.
REQ-010 SHALL have ports dl_ds out 2 ({addr[0], ~addr[0]}), ioctl_wait out 1, core_mod out 8, dip out DIP_BYTES*8, rom_loaded out 1, core_reset out 1, err_overrun out 1 and err_timeout out 1.

Function
REQ-011 SHALL detect a write event as ioctl_wr high while its registered copy is low.
REQ-012 SHALL treat a write event with ioctl_download=1 and ioctl_index=ROM_INDEX as a ROM write.
REQ-013 SHALL define region i as hit when REGION_BASE[i] <= addr < REGION_BASE[i]+REGION_SIZE[i], compared at ADDR_W+1 bits with no wrap; overlapping regions may hit simultaneously.
REQ-014 SHALL run FSM IDLE/WAIT_ACK; in IDLE, on a ROM write, register dl_data, dl_ds and every region_offset, and toggle region_req[i] for each hit region, all in one cycle.
REQ-015 SHALL move to WAIT_ACK after a write with >=1 hit; a write with zero hits SHALL be ignored and the FSM stays in IDLE.
REQ-016 SHALL treat pending[i] = region_req[i] XOR region_ack[i]; in WAIT_ACK, when no bit is pending, SHALL return to IDLE on the next cycle.
REQ-017 SHALL drive ioctl_wait=1 exactly while in WAIT_ACK.
REQ-018 SHALL count cycles in WAIT_ACK; on reaching TIMEOUT it SHALL set err_timeout (sticky) and return to IDLE without re-toggling region_req.
REQ-019 SHALL drop a ROM write that arrives in WAIT_ACK and set err_overrun (sticky).
REQ-020 SHALL, on a write event with ioctl_index=MOD_INDEX, load core_mod <= ioctl_dout (last byte wins).
REQ-021 SHALL, on a write event with ioctl_index=DIP_INDEX and addr < DIP_BYTES, write dip byte [addr]; other addresses are ignored.
REQ-022 SHALL set rom_loaded on the cycle after a falling edge of ioctl_download while ioctl_index=ROM_INDEX; rom_loaded is never cleared except by rst_n.
REQ-023 SHALL reload the reset counter to all-ones while soft_reset=1, rom_loaded=0 or a ROM download is active, and otherwise decrement it to 0 and hold.
REQ-024 SHALL register core_reset = (counter != 0).
REQ-025 SHALL clear err_overrun and err_timeout at the start of a new ROM download (rising ioctl_download with ROM_INDEX).

Reset
REQ-026 SHALL, on rst_n low, set FSM=IDLE, region_req=0, region_offset=0, dl_data=0, dl_ds=0, ioctl_wait=0, core_mod=0, dip=0, rom_loaded=0, errors=0, counter all-ones, core_reset=1.
REQ-027 SHALL abandon any pending request on reset mid-transfer; no req toggles on the first cycle after rst_n release.

Structure
REQ-028 SHALL place index constants, the FSM state typedef and the region base/size defaults in shared package ioctl_pkg.
REQ-029 SHALL implement the reset counter as the single sub-module core_reset_gen.

Verification
REQ-030 Scenario: ROM write at 0x00010 with ack looped back after 3 cycles -> region_req[0] toggles, region_req[1] does not, region_offset[0]=0x10, ioctl_wait high for 4 cycles.
REQ-031 Scenario: ROM write at 0x30001 -> both reqs toggle; region_offset[1]=0x00001; dl_ds=2'b10.
REQ-032 Scenario: ROM write at 0xA0000 -> no toggle, ioctl_wait stays 0.
REQ-033 Scenario: ack withheld -> err_timeout=1 after 1024 cycles in WAIT_ACK; a second write during the wait -> err_overrun=1.
REQ-034 Scenario: DIP_INDEX writes 0x5A at addr 2 and 0xFF at addr 9 -> dip byte2=0x5A, no other change; MOD_INDEX writes 0x0B -> core_mod=0x0B.
REQ-035 Scenario: ROM download ends -> rom_loaded=1 and core_reset falls 65535 cycles later; soft_reset pulse -> core_reset high again; rst_n low mid-wait -> all outputs return to reset values.
